color_sync_ctrl: RTL and testbench
==================================

COLOR_SYNC_CTRL -- requirements
Module: color_sync_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000, meaning consecutive stable vga_clk cycles required to accept a new switch level (10 ms at 25 MHz).
REQ-002 SHALL have parameter CYCLE_FRAMES, default 60, meaning frames per colour step in auto-cycle mode (range 1..1023).
REQ-003 SHALL have port vga_clk  input  1  the single clock for all logic; the VGA pixel clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports red_sw, green_sw, blue_sw  input  1 each  raw board switches; asynchronous and bouncing.
REQ-006 SHALL have port cycle_sw  input  1  raw mode switch; 1 selects auto-cycle.
REQ-007 SHALL have port vsync  input  1  active-low vertical sync from the VGA timing block.
REQ-008 SHALL have ports red_in, green_in, blue_in  output  1 each  registered colour enables driven to the VGA datapath.
REQ-009 SHALL have port frame_tick  output  1  one-cycle pulse at each detected frame start.
REQ-010 SHALL have port cycling  output  1  high while the FSM is in CYCLE.

Function
REQ-011 SHALL pass each raw switch and vsync through a two-flop synchronizer before any other use.
REQ-012 SHALL debounce each synchronized switch independently: a per-switch counter increments while the synchronized level differs from the debounced level, clears whenever the levels match, and updates the debounced level when the counter reaches DEBOUNCE_CYCLES-1 (counter then clears).
REQ-013 SHALL assert frame_tick for exactly one cycle, on the cycle after the synchronized vsync is sampled 0 having been 1 the previous cycle (falling edge).
REQ-014 SHALL implement a two-state FSM, MANUAL and CYCLE; it transitions only on frame_tick cycles.
REQ-015 In MANUAL on frame_tick: if debounced cycle_sw=1, SHALL go to CYCLE, load colour counter to 3'b000, clear frame counter, and drive outputs 000; otherwise SHALL load {red_in,green_in,blue_in} from the debounced {red,green,blue} switches.
REQ-016 In CYCLE on frame_tick: if debounced cycle_sw=0, SHALL go to MANUAL and load outputs from the debounced switches on that same tick.
REQ-017 In CYCLE on frame_tick with cycle_sw=1: frame counter SHALL increment; when it reaches CYCLE_FRAMES-1 it SHALL clear and the 3-bit colour counter SHALL increment, wrapping 3'b111 to 3'b000.
REQ-018 In CYCLE, {red_in,green_in,blue_in} SHALL equal the colour counter, bit 2 = red, registered and updated in the tick cycle.
REQ-019 Outputs SHALL NOT change on any cycle other than a frame_tick cycle (no mid-frame tearing).
REQ-020 When a mode change and a colour-step expiry coincide on one tick, the mode change SHALL win and the colour counter SHALL NOT step.
REQ-021 cycling SHALL be high exactly while the state is CYCLE.
REQ-022 Counter widths SHALL be clog2-sized from the parameters; no counter SHALL overflow for any legal parameter value.

Reset
REQ-023 On reset high, SHALL immediately (asynchronously) force state MANUAL, all outputs 0, all synchronizer flops, debounced levels and counters 0.
REQ-024 Reset asserted mid-frame or mid-debounce SHALL discard all partial counts; after release, the first frame_tick SHALL require a fresh vsync falling edge.

Verification (DEBOUNCE_CYCLES=4, CYCLE_FRAMES=2)
REQ-025 Hold red_sw=1 steady, others 0, then one vsync falling edge -> red_in,green_in,blue_in = 1,0,0 in the frame_tick cycle; unchanged before the tick.
REQ-026 Toggle green_sw 1/0 every 2 cycles for 20 cycles, then hold 0 -> debounced green never changes; green_in stays 0 across ticks.
REQ-027 cycle_sw=1 steady, 18 vsync edges -> cycling=1 after tick 1; outputs 000,000,001,001,010,... wrapping 111 to 000 after tick 17.
REQ-028 In CYCLE, drop cycle_sw on a tick where the colour step is due -> state MANUAL, outputs equal switch values, colour counter not stepped.
REQ-029 Assert reset mid-frame with outputs 101 and state CYCLE -> outputs 000 and cycling=0 in the same cycle without a clock edge; after release, no frame_tick until the next vsync falling edge.

Source files
------------

// File: rtl/color_sync_ctrl.sv
// Switch-driven colour enable controller for a VGA datapath: synchronises and
// debounces the board switches, and updates the colour only at frame start.
module color_sync_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CYCLE_FRAMES    = 60
) (
  input  logic vga_clk,
  input  logic reset,
  input  logic red_sw,
  input  logic green_sw,
  input  logic blue_sw,
  input  logic cycle_sw,
  input  logic vsync,
  output logic red_in,
  output logic green_in,
  output logic blue_in,
  output logic frame_tick,
  output logic cycling
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int FC_W = (CYCLE_FRAMES > 1) ? $clog2(CYCLE_FRAMES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(CYCLE_FRAMES - 1);

  typedef enum logic {MANUAL, CYCLE} state_t;

  // Bit order everywhere: [4]=cycle, [3]=red, [2]=green, [1]=blue, [0]=vsync.
  logic [4:0] raw;
  logic [4:0] sync1;
  logic [4:0] sync2;
  logic [3:0] sw_sync;
  logic       vs_sync;

  assign raw     = {cycle_sw, red_sw, green_sw, blue_sw, vsync};
  assign sw_sync = sync2[4:1];
  assign vs_sync = sync2[0];

  // NOTE: non-blocking assignments keep the two stages distinct flops; a
  // blocking chain here would collapse the synchronizer into one register.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce: [3]=cycle, [2]=red, [1]=green, [0]=blue.
  logic [3:0]      sw_db;
  logic [DB_W-1:0] db_cnt [4];

  // NOTE: the counter array is reset element by element; a partial count
  // must never survive reset or a half-settled switch could flip early.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      sw_db <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sw_sync[i] == sw_db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          sw_db[i]  <= sw_sync[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic vs_prev;
  logic tick_d;

  assign tick_d = vs_prev & ~vs_sync;

  state_t          state;
  logic [2:0]      color;
  logic [FC_W-1:0] frame_cnt;
  logic [2:0]      rgb;

  // Everything visible changes on the edge that raises frame_tick, so the
  // new colour is already present during the tick cycle.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      vs_prev    <= 1'b0;
      frame_tick <= 1'b0;
      state      <= MANUAL;
      color      <= '0;
      frame_cnt  <= '0;
      rgb        <= '0;
    end else begin
      vs_prev    <= vs_sync;
      frame_tick <= tick_d;
      if (tick_d) begin
        case (state)
          MANUAL: begin
            if (sw_db[3]) begin
              state     <= CYCLE;
              color     <= '0;
              frame_cnt <= '0;
              rgb       <= '0;
            end else begin
              rgb <= sw_db[2:0];
            end
          end
          CYCLE: begin
            // Leaving CYCLE takes priority over a due colour step.
            if (!sw_db[3]) begin
              state <= MANUAL;
              rgb   <= sw_db[2:0];
            end else if (frame_cnt == FC_LAST) begin
              frame_cnt <= '0;
              color     <= color + 3'd1;
              rgb       <= color + 3'd1;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
              rgb       <= color;
            end
          end
          default: state <= MANUAL;
        endcase
      end
    end
  end

  assign {red_in, green_in, blue_in} = rgb;
  assign cycling = (state == CYCLE);

endmodule

// File: tb/tb_color_sync_ctrl.sv
// Scoreboard bench for color_sync_ctrl: each vsync falling edge pushes the
// expected {cycling,r,g,b}; a negedge monitor pops on every frame_tick.
module tb_color_sync_ctrl;

  logic vga_clk = 1'b0;
  logic reset   = 1'b1;
  logic red_sw = 1'b0, green_sw = 1'b0, blue_sw = 1'b0, cycle_sw = 1'b0;
  logic vsync   = 1'b1;
  logic red_in, green_in, blue_in, frame_tick, cycling;

  int tests = 0;
  int fails = 0;

  logic [3:0] exp_q [$];
  logic [3:0] last_exp = 4'b0000;
  logic [3:0] popped;
  logic       prev_ft = 1'b0;

  color_sync_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .CYCLE_FRAMES   (2)
  ) dut (
    .vga_clk   (vga_clk),
    .reset     (reset),
    .red_sw    (red_sw),
    .green_sw  (green_sw),
    .blue_sw   (blue_sw),
    .cycle_sw  (cycle_sw),
    .vsync     (vsync),
    .red_in    (red_in),
    .green_in  (green_in),
    .blue_in   (blue_in),
    .frame_tick(frame_tick),
    .cycling   (cycling)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge vga_clk);
      #1;
    end
  endtask

  // One frame: vsync low for three cycles, then high long enough for the
  // tick to have come and gone before the next frame starts.
  task automatic frame(input logic [3:0] exp);
    exp_q.push_back(exp);
    vsync = 1'b0;
    wait_cyc(3);
    vsync = 1'b1;
    wait_cyc(4);
    check("tick_seen", exp_q.size(), 0);
  endtask

  // Monitor: tick cycles pop the scoreboard, all other cycles must hold.
  always @(negedge vga_clk) begin
    if (reset) begin
      last_exp = 4'b0000;
      prev_ft  = 1'b0;
    end else if (frame_tick) begin
      check("tick_width", prev_ft, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_tick", 1, 0);
      end else begin
        popped = exp_q.pop_front();
        check("tick_out", {cycling, red_in, green_in, blue_in}, popped);
        last_exp = popped;
      end
      prev_ft = 1'b1;
    end else begin
      check("hold_out", {cycling, red_in, green_in, blue_in}, last_exp);
      prev_ft = 1'b0;
    end
  end

  initial begin
    int n;
    wait_cyc(2);
    check("reset_out", {cycling, red_in, green_in, blue_in}, 4'b0000);
    check("reset_tick", frame_tick, 0);
    reset = 1'b0;
    wait_cyc(5);

    // Manual mode with a few distinct switch patterns.
    red_sw = 1'b1;
    wait_cyc(10);
    frame(4'b0100);
    {red_sw, green_sw, blue_sw} = 3'b011;
    wait_cyc(10);
    frame(4'b0011);
    {red_sw, green_sw, blue_sw} = 3'b101;
    wait_cyc(10);
    frame(4'b0101);

    // Green bouncing with 2-cycle pulses never reaches the threshold.
    {red_sw, green_sw, blue_sw} = 3'b100;
    wait_cyc(10);
    frame(4'b0100);
    for (int i = 0; i < 10; i++) begin
      green_sw = ~green_sw;
      wait_cyc(2);
    end
    wait_cyc(10);
    frame(4'b0100);
    frame(4'b0100);

    // Auto-cycle: two frames per colour step, wrapping after 111.
    {red_sw, green_sw, blue_sw} = 3'b101;
    cycle_sw = 1'b1;
    wait_cyc(10);
    for (int i = 1; i <= 18; i++) frame({1'b1, 3'((i - 1) / 2)});

    // A step is due on the next tick; leaving CYCLE wins.
    cycle_sw = 1'b0;
    wait_cyc(10);
    frame(4'b0101);

    // Re-enter CYCLE and run to colour 101, then reset mid-frame.
    cycle_sw = 1'b1;
    wait_cyc(10);
    for (int i = 1; i <= 11; i++) frame({1'b1, 3'((i - 1) / 2)});
    wait_cyc(2);
    #2;
    check("pre_reset", {cycling, red_in, green_in, blue_in}, 4'b1101);
    reset = 1'b1;
    #1;
    check("async_reset_out", {cycling, red_in, green_in, blue_in}, 4'b0000);
    check("async_reset_tick", frame_tick, 0);
    wait_cyc(3);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      wait_cyc(1);
      n += int'(frame_tick);
    end
    check("no_tick_after_reset", n, 0);

    frame(4'b1000);
    frame(4'b1000);
    cycle_sw = 1'b0;
    wait_cyc(10);
    frame(4'b0101);

    wait_cyc(3);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
